trig_link_sequencer: RTL and testbench

TRIG_LINK_SEQUENCER -- requirements
Module: trig_link_sequencer

---
 rtl/trig_link_sequencer_if.sv | 32 +++
 rtl/trig_link_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_trig_link_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/trig_link_sequencer_if.sv
// Bundle between the trigger-link sequencer and its readiness, payload and transceiver neighbours.
// The sequencer is the slave; the master side drives readiness/payload and observes the link.
`timescale 1ns/1ps
interface trig_link_sequencer_if;
    logic        TRG_TXRESETDONE;
    logic        TX_SYNC_DONE;
    logic        TRG_TX_PLL_LOCK;
    logic        RESYNC_REQ;
    logic [55:0] GEM_DATA;
    logic        GEM_VALID;
    logic        GEM_OVERFLOW;
    logic        ENA_TEST_PAT;
    logic        GEM_ACK;
    logic [31:0] TX_DATA;
    logic [3:0]  TX_ISK;
    logic        LINK_READY;
    logic [1:0]  STATE;
    logic [31:0] FRAME_CNT;
    logic [15:0] OVF_CNT;

    modport master (
        output TRG_TXRESETDONE, TX_SYNC_DONE, TRG_TX_PLL_LOCK, RESYNC_REQ,
               GEM_DATA, GEM_VALID, GEM_OVERFLOW, ENA_TEST_PAT,
        input  GEM_ACK, TX_DATA, TX_ISK, LINK_READY, STATE, FRAME_CNT, OVF_CNT
    );

    modport slave (
        input  TRG_TXRESETDONE, TX_SYNC_DONE, TRG_TX_PLL_LOCK, RESYNC_REQ,
               GEM_DATA, GEM_VALID, GEM_OVERFLOW, ENA_TEST_PAT,
        output GEM_ACK, TX_DATA, TX_ISK, LINK_READY, STATE, FRAME_CNT, OVF_CNT
    );
endinterface

// File: rtl/trig_link_sequencer.sv
// Trigger link sequencer: waits for a stable transceiver, sends comma sync frames,
// then streams 56-bit cluster payloads as two-word frames with a rotating K-char separator.
`timescale 1ns/1ps
module trig_link_sequencer #(
    parameter int unsigned LOCK_CYCLES  = 256,
    parameter int unsigned SYNC_FRAMES  = 64,
    parameter logic [55:0] IDLE_PAYLOAD = 56'h0,
    parameter logic [15:0] OVF_MAX      = 16'hFFFF
) (
    input logic                   TRG_CLK80,
    input logic                   TRG_RST,
    trig_link_sequencer_if.slave  lnk
);
    typedef enum logic [1:0] {WAIT_READY = 2'b00, SYNC = 2'b01, RUN = 2'b10} state_t;

    localparam logic [31:0] COMMA_DATA = 32'h50BC50BC;
    localparam logic [3:0]  COMMA_ISK  = 4'b0101;
    localparam int          RDY_W      = $clog2(LOCK_CYCLES + 1);
    localparam int          SYNC_W     = $clog2(2 * SYNC_FRAMES + 1);
    localparam logic [RDY_W-1:0]  RDY_LAST  = RDY_W'(LOCK_CYCLES - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(2 * SYNC_FRAMES - 1);

    function automatic logic [7:0] sep_byte(input logic ovf, input logic [1:0] idx);
        if (ovf) return 8'hFC;
        case (idx)
            2'd0:    return 8'hBC;
            2'd1:    return 8'hF7;
            2'd2:    return 8'hFB;
            default: return 8'hFD;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= OVF_MAX) ? OVF_MAX : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic [RDY_W-1:0]    rdy_cnt_q, rdy_cnt_d;
    logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [1:0]          sep_idx_q, sep_idx_d;
    logic                resync_q, resync_d;
    logic [47:0]         test_cnt_q, test_cnt_d;
    logic                vld_hold_q, vld_hold_d;
    logic                ovf_hold_q, ovf_hold_d;
    logic [23:0]         hold_q, hold_d;
    logic [31:0]         tx_data_q, tx_data_d;
    logic [3:0]          tx_isk_q, tx_isk_d;
    logic                link_ready_q, link_ready_d;
    logic [31:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         ovf_cnt_q, ovf_cnt_d;
    logic                all_rdy;
    logic                gem_ack;
    logic [55:0]         payload;

    always_comb begin
        all_rdy = lnk.TRG_TXRESETDONE & lnk.TX_SYNC_DONE & lnk.TRG_TX_PLL_LOCK;
        payload = lnk.ENA_TEST_PAT ? {8'h5A, test_cnt_q} :
                  lnk.GEM_VALID    ? lnk.GEM_DATA : IDLE_PAYLOAD;

        state_d     = state_q;
        phase_d     = phase_q;
        rdy_cnt_d   = rdy_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        sep_idx_d   = sep_idx_q;
        resync_d    = resync_q;
        test_cnt_d  = test_cnt_q;
        vld_hold_d  = vld_hold_q;
        ovf_hold_d  = ovf_hold_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        tx_data_d   = COMMA_DATA;
        tx_isk_d    = COMMA_ISK;
        gem_ack     = 1'b0;

        case (state_q)
            WAIT_READY: begin
                phase_d    = 1'b0;
                sync_cnt_d = '0;
                resync_d   = 1'b0;
                if (!all_rdy) begin
                    rdy_cnt_d = '0;
                end else if (rdy_cnt_q == RDY_LAST) begin
                    state_d   = SYNC;
                    rdy_cnt_d = '0;
                end else begin
                    rdy_cnt_d = rdy_cnt_q + RDY_W'(1);
                end
            end
            SYNC: begin
                // Comma count is even, so leaving here always lands on a frame boundary.
                phase_d = 1'b0;
                if (!all_rdy) begin
                    state_d   = WAIT_READY;
                    rdy_cnt_d = '0;
                end else if (sync_cnt_q == SYNC_LAST) begin
                    state_d    = RUN;
                    sync_cnt_d = '0;
                    sep_idx_d  = 2'd0;
                    test_cnt_d = '0;
                end else begin
                    sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                end
            end
            RUN: begin
                if (!all_rdy) begin
                    state_d   = WAIT_READY;
                    rdy_cnt_d = '0;
                    phase_d   = 1'b0;
                    resync_d  = 1'b0;
                end else if (!phase_q) begin
                    gem_ack    = 1'b1;
                    hold_d     = payload[23:0];
                    vld_hold_d = lnk.ENA_TEST_PAT | lnk.GEM_VALID;
                    ovf_hold_d = lnk.GEM_OVERFLOW;
                    if (lnk.ENA_TEST_PAT) test_cnt_d = test_cnt_q + 48'd1;
                    if (lnk.RESYNC_REQ)   resync_d   = 1'b1;
                    tx_data_d  = payload[55:24];
                    tx_isk_d   = 4'b0000;
                    phase_d    = 1'b1;
                end else begin
                    tx_data_d = {hold_q, sep_byte(ovf_hold_q, sep_idx_q)};
                    tx_isk_d  = 4'b0001;
                    phase_d   = 1'b0;
                    sep_idx_d = sep_idx_q + 2'd1;
                    if (vld_hold_q) frame_cnt_d = frame_cnt_q + 32'd1;
                    if (ovf_hold_q) ovf_cnt_d   = sat_inc(ovf_cnt_q);
                    if (resync_q || lnk.RESYNC_REQ) begin
                        state_d    = SYNC;
                        sync_cnt_d = '0;
                        resync_d   = 1'b0;
                    end
                end
            end
            default: state_d = WAIT_READY;
        endcase

        link_ready_d = (state_d == RUN);
    end

    always_ff @(posedge TRG_CLK80) begin
        if (TRG_RST) begin
            state_q      <= WAIT_READY;
            phase_q      <= 1'b0;
            rdy_cnt_q    <= '0;
            sync_cnt_q   <= '0;
            sep_idx_q    <= 2'd0;
            resync_q     <= 1'b0;
            test_cnt_q   <= '0;
            vld_hold_q   <= 1'b0;
            ovf_hold_q   <= 1'b0;
            tx_data_q    <= COMMA_DATA;
            tx_isk_q     <= COMMA_ISK;
            link_ready_q <= 1'b0;
            frame_cnt_q  <= '0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            rdy_cnt_q    <= rdy_cnt_d;
            sync_cnt_q   <= sync_cnt_d;
            sep_idx_q    <= sep_idx_d;
            resync_q     <= resync_d;
            test_cnt_q   <= test_cnt_d;
            vld_hold_q   <= vld_hold_d;
            ovf_hold_q   <= ovf_hold_d;
            tx_data_q    <= tx_data_d;
            tx_isk_q     <= tx_isk_d;
            link_ready_q <= link_ready_d;
            frame_cnt_q  <= frame_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    // Payload low bits are pure data and only read after a capture, so no reset.
    always_ff @(posedge TRG_CLK80) begin
        hold_q <= hold_d;
    end

    assign lnk.GEM_ACK    = gem_ack;
    assign lnk.TX_DATA    = tx_data_q;
    assign lnk.TX_ISK     = tx_isk_q;
    assign lnk.LINK_READY = link_ready_q;
    assign lnk.STATE      = state_q;
    assign lnk.FRAME_CNT  = frame_cnt_q;
    assign lnk.OVF_CNT    = ovf_cnt_q;
endmodule

// File: tb/tb_trig_link_sequencer.sv
// Bench for trig_link_sequencer: bring-up, framing/separators, resync, test pattern,
// overflow saturation, ready loss and mid-frame reset, with a word scoreboard.
`timescale 1ns/1ps
module tb_trig_link_sequencer;
    localparam int unsigned LOCK_CYCLES  = 4;
    localparam int unsigned SYNC_FRAMES  = 2;
    localparam logic [55:0] IDLE_PAYLOAD = 56'hC0FFEE00112233;
    localparam logic [15:0] OVF_MAX      = 16'd4;
    localparam logic [31:0] COMMA        = 32'h50BC50BC;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];

    trig_link_sequencer_if bus ();

    trig_link_sequencer #(
        .LOCK_CYCLES  (LOCK_CYCLES),
        .SYNC_FRAMES  (SYNC_FRAMES),
        .IDLE_PAYLOAD (IDLE_PAYLOAD),
        .OVF_MAX      (OVF_MAX)
    ) dut (
        .TRG_CLK80 (clk),
        .TRG_RST   (rst),
        .lnk       (bus)
    );

    always #6.25 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [55:0] pl, input logic [7:0] sep);
        exp_q.push_back({pl[55:24], 4'b0000});
        exp_q.push_back({pl[23:0], sep, 4'b0001});
    endtask

    task automatic pop_check(input string tag);
        word_t w;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            w = exp_q.pop_front();
            check({tag, "_data"}, 64'(bus.TX_DATA), 64'(w.d));
            check({tag, "_isk"},  64'(bus.TX_ISK),  64'(w.k));
        end
    endtask

    task automatic check_comma(input string tag);
        check({tag, "_comma"}, 64'(bus.TX_DATA), 64'(COMMA));
        check({tag, "_kisk"},  64'(bus.TX_ISK),  64'(4'b0101));
    endtask

    // Drives one RUN frame starting in a capture cycle; rs pulses RESYNC_REQ during word0.
    task automatic run_frame(input logic [55:0] data, input logic vld, input logic ovf,
                             input logic ena, input logic rs, input logic [55:0] exp_pl,
                             input logic [7:0] exp_sep, input logic [31:0] exp_fc,
                             input logic [15:0] exp_oc);
        bus.GEM_DATA     = data;
        bus.GEM_VALID    = vld;
        bus.GEM_OVERFLOW = ovf;
        bus.ENA_TEST_PAT = ena;
        #1;
        check("ack_cap", 64'(bus.GEM_ACK), 64'd1);
        push_frame(exp_pl, exp_sep);
        tick();
        bus.GEM_DATA     = '1;
        bus.GEM_VALID    = 1'b0;
        bus.GEM_OVERFLOW = 1'b0;
        bus.ENA_TEST_PAT = 1'b0;
        bus.RESYNC_REQ   = rs;
        #1;
        check("ack_w0", 64'(bus.GEM_ACK), 64'd0);
        check("link_ready", 64'(bus.LINK_READY), 64'd1);
        pop_check("w0");
        tick();
        bus.RESYNC_REQ = 1'b0;
        pop_check("w1");
        check("frame_cnt", 64'(bus.FRAME_CNT), 64'(exp_fc));
        check("ovf_cnt",   64'(bus.OVF_CNT),   64'(exp_oc));
        check("state_after", 64'(bus.STATE), rs ? 64'd1 : 64'd2);
    endtask

    task automatic sync_to_run(input logic poke_resync);
        for (int i = 0; i < 3; i++) begin
            bus.RESYNC_REQ = poke_resync && (i == 0);
            tick();
            bus.RESYNC_REQ = 1'b0;
            check("st_sync", 64'(bus.STATE), 64'd1);
            check_comma("sync");
        end
        tick();
        check("st_run", 64'(bus.STATE), 64'd2);
        check("run_ready", 64'(bus.LINK_READY), 64'd1);
        check_comma("run_entry");
    endtask

    initial begin
        bus.TRG_TXRESETDONE = 1'b1;
        bus.TX_SYNC_DONE    = 1'b1;
        bus.TRG_TX_PLL_LOCK = 1'b1;
        bus.RESYNC_REQ      = 1'b0;
        bus.GEM_DATA        = '0;
        bus.GEM_VALID       = 1'b0;
        bus.GEM_OVERFLOW    = 1'b0;
        bus.ENA_TEST_PAT    = 1'b0;
        tick();
        tick();
        check("rst_state", 64'(bus.STATE), 64'd0);
        check_comma("rst");
        check("rst_ready", 64'(bus.LINK_READY), 64'd0);
        check("rst_frame", 64'(bus.FRAME_CNT), 64'd0);
        check("rst_ovf",   64'(bus.OVF_CNT), 64'd0);
        check("rst_ack",   64'(bus.GEM_ACK), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_wait", 64'(bus.STATE), 64'd0);
            check_comma("wait");
        end
        tick();
        check("st_sync0", 64'(bus.STATE), 64'd1);
        check_comma("sync0");
        sync_to_run(1'b0);

        run_frame(56'h123456789ABCDE, 1'b1, 1'b0, 1'b0, 1'b0, 56'h123456789ABCDE, 8'hBC, 32'd1, 16'd0);
        run_frame(56'h0,              1'b0, 1'b0, 1'b0, 1'b0, IDLE_PAYLOAD,       8'hF7, 32'd1, 16'd0);
        run_frame(56'hA1A2A3A4A5A6A7, 1'b1, 1'b1, 1'b0, 1'b0, 56'hA1A2A3A4A5A6A7, 8'hFC, 32'd2, 16'd1);
        run_frame(56'h0F0E0D0C0B0A09, 1'b1, 1'b0, 1'b0, 1'b0, 56'h0F0E0D0C0B0A09, 8'hFD, 32'd3, 16'd1);
        run_frame(56'hFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 56'hFFFFFFFFFFFFFF, 8'hBC, 32'd4, 16'd1);

        run_frame(56'h00000000000001, 1'b1, 1'b0, 1'b0, 1'b1, 56'h00000000000001, 8'hF7, 32'd5, 16'd1);
        sync_to_run(1'b1);

        run_frame(56'h0, 1'b0, 1'b0, 1'b1, 1'b0, 56'h5A000000000000, 8'hBC, 32'd6, 16'd1);
        run_frame(56'h0, 1'b0, 1'b0, 1'b1, 1'b0, 56'h5A000000000001, 8'hF7, 32'd7, 16'd1);

        run_frame(56'h11111111111111, 1'b1, 1'b1, 1'b0, 1'b0, 56'h11111111111111, 8'hFC, 32'd8,  16'd2);
        run_frame(56'h22222222222222, 1'b1, 1'b1, 1'b0, 1'b0, 56'h22222222222222, 8'hFC, 32'd9,  16'd3);
        run_frame(56'h33333333333333, 1'b1, 1'b1, 1'b0, 1'b0, 56'h33333333333333, 8'hFC, 32'd10, 16'd4);
        run_frame(56'h44444444444444, 1'b1, 1'b1, 1'b0, 1'b0, 56'h44444444444444, 8'hFC, 32'd11, 16'd4);
        run_frame(56'h55555555555555, 1'b1, 1'b0, 1'b0, 1'b0, 56'h55555555555555, 8'hFB, 32'd12, 16'd4);

        bus.GEM_DATA     = 56'hDEADBEEFDEADBE;
        bus.GEM_VALID    = 1'b1;
        bus.TX_SYNC_DONE = 1'b0;
        #1;
        check("ack_loss", 64'(bus.GEM_ACK), 64'd0);
        tick();
        bus.GEM_VALID = 1'b0;
        check("loss_state", 64'(bus.STATE), 64'd0);
        check("loss_ready", 64'(bus.LINK_READY), 64'd0);
        check_comma("loss");
        bus.TX_SYNC_DONE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("relock_a", 64'(bus.STATE), 64'd0);
        end
        bus.TX_SYNC_DONE = 1'b0;
        tick();
        check("relock_drop", 64'(bus.STATE), 64'd0);
        bus.TX_SYNC_DONE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("relock_b", 64'(bus.STATE), 64'd0);
            check_comma("relock_b");
        end
        tick();
        check("relock_sync", 64'(bus.STATE), 64'd1);
        sync_to_run(1'b0);
        run_frame(56'h01020304050607, 1'b1, 1'b0, 1'b0, 1'b0, 56'h01020304050607, 8'hBC, 32'd13, 16'd4);

        bus.GEM_DATA  = 56'hCAFEF00D123456;
        bus.GEM_VALID = 1'b1;
        #1;
        check("ack_prerst", 64'(bus.GEM_ACK), 64'd1);
        tick();
        bus.GEM_VALID = 1'b0;
        check("w0_prerst", 64'(bus.TX_DATA), 64'(32'hCAFEF00D));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_state", 64'(bus.STATE), 64'd0);
        check_comma("mrst");
        check("mrst_ready", 64'(bus.LINK_READY), 64'd0);
        check("mrst_frame", 64'(bus.FRAME_CNT), 64'd0);
        check("mrst_ovf",   64'(bus.OVF_CNT), 64'd0);
        check("mrst_ack",   64'(bus.GEM_ACK), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
